// File: rtl/led_status_ctrl.sv
// rtl/led_status_ctrl.sv - SRAM test status LED sequencer; LED_STATUS_HEARTBEAT_EN selects heartbeat on led_3
module led_status_ctrl #(
    parameter int TICK_DIV      = 25000000,
    parameter int TICK_W        = 25,
    parameter int TIMEOUT_TICKS = 20,
    parameter int TO_W          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       test_start,
    input  logic       test_done,
    input  logic       test_pass,
    input  logic       err_pulse,
    input  logic       clr,
    output logic       led_0,
    output logic       led_1,
    output logic       led_2,
    output logic       led_3,
    output logic [1:0] state,
    output logic       timeout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PASS = 2'd2;
    localparam logic [1:0] S_FAIL = 2'd3;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_TICKS - 1);

    logic [TICK_W-1:0] pre_cnt;
    logic              tick;
    logic              phase;
    logic [TO_W-1:0]   to_cnt;
    logic              err_seen;
    logic [3:0]        led_nxt;

    assign tick = (pre_cnt == TICK_LAST);

    // Free-running blink prescaler; phase flips once per tick, independent of the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            phase   <= 1'b0;
        end else if (tick) begin
            pre_cnt <= '0;
            phase   <= ~phase;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Run tracker: start beats clr beats done beats timeout expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            err_seen <= 1'b0;
            timeout  <= 1'b0;
            to_cnt   <= '0;
        end else if (test_start) begin
            state    <= S_RUN;
            err_seen <= 1'b0;
            timeout  <= 1'b0;
            to_cnt   <= '0;
        end else if (clr) begin
            state    <= S_IDLE;
            err_seen <= 1'b0;
            timeout  <= 1'b0;
        end else if (state == S_RUN) begin
            if (err_pulse) begin
                err_seen <= 1'b1;
            end
            if (tick) begin
                to_cnt <= to_cnt + 1'b1;
            end
            // A miscompare in the same cycle as done still spoils the verdict.
            if (test_done) begin
                state <= (test_pass && !err_seen && !err_pulse) ? S_PASS : S_FAIL;
            end else if (tick && (to_cnt == TO_LAST)) begin
                state   <= S_FAIL;
                timeout <= 1'b1;
            end
        end
    end

    // LED pattern for the current state, registered below.
    always_comb begin
        led_nxt = 4'b0000;
        case (state)
            S_RUN: begin
                led_nxt[0] = phase;
                led_nxt[2] = err_seen;
            end
            S_PASS:  led_nxt[1] = 1'b1;
            S_FAIL:  led_nxt[2] = phase;
            default: led_nxt = 4'b0000;
        endcase
`ifdef LED_STATUS_HEARTBEAT_EN
        led_nxt[3] = ((state == S_FAIL) && timeout) ? 1'b1 : phase;
`else
        led_nxt[3] = timeout;
`endif
    end

    // Registered LED drivers, one cycle behind the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {led_3, led_2, led_1, led_0} <= 4'b0000;
        end else begin
            {led_3, led_2, led_1, led_0} <= led_nxt;
        end
    end

endmodule

// File: tb/tb_led_status_ctrl.sv
// tb/tb_led_status_ctrl.sv - scoreboard bench for led_status_ctrl
module tb_led_status_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       test_start, test_done, test_pass, err_pulse, clr;
    logic       led_0, led_1, led_2, led_3;
    logic [1:0] state;
    logic       timeout;

`ifdef LED_STATUS_HEARTBEAT_EN
    localparam bit HB = 1'b1;
`else
    localparam bit HB = 1'b0;
`endif

    // observation word: {timeout, state[1:0], led_3, led_2, led_1, led_0}
    localparam logic [6:0] M_ALL = 7'h7F;
    localparam logic [6:0] M_ST  = 7'h70;

    typedef struct {
        int         cyc;
        logic [6:0] val;
        logic [6:0] mask;
        logic [95:0] tag;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t mon_e;
    logic [6:0] mon_obs;
    int   s_cyc, d_cyc, e_cyc, t_cyc;

    led_status_ctrl #(
        .TICK_DIV(4), .TICK_W(3), .TIMEOUT_TICKS(5), .TO_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .test_start(test_start), .test_done(test_done), .test_pass(test_pass),
        .err_pulse(err_pulse), .clr(clr),
        .led_0(led_0), .led_1(led_1), .led_2(led_2), .led_3(led_3),
        .state(state), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges since reset was last released
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [6:0] mk(input logic [1:0] st, input logic to,
                                      input logic l3, input logic l2, input logic l1, input logic l0);
        return {to, st, l3, l2, l1, l0};
    endfunction

    // phase value the LED register sampled at edge e (TICK_DIV=4: ticks at edges 4,8,...)
    function automatic logic phb(input int e);
        return (((e - 1) / 4) % 2) != 0;
    endfunction

    // led_3 registered at edge e given the state/timeout held before that edge
    function automatic logic l3x(input logic [1:0] st, input logic to, input int e);
        if (HB) return (st == 2'd3 && to) ? 1'b1 : phb(e);
        return to;
    endfunction

    task automatic expect_at(input int c, input logic [6:0] v, input logic [6:0] m, input logic [95:0] tag);
        exp_t x;
        x.cyc = c; x.val = v; x.mask = m; x.tag = tag;
        q.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation due at this cycle; a skipped one counts as missed.
    always @(negedge clk) begin
        mon_obs = {timeout, state, led_3, led_2, led_1, led_0};
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            n_vec++;
            if (mon_e.cyc != cyc) begin
                n_bad++;
                $display("FAIL %0s: due cycle %0d never sampled (now %0d)", mon_e.tag, mon_e.cyc, cyc);
            end else if ((mon_obs & mon_e.mask) !== (mon_e.val & mon_e.mask)) begin
                n_bad++;
                $display("FAIL %0s cycle %0d: got %b, want %b (mask %b)",
                         mon_e.tag, cyc, mon_obs, mon_e.val, mon_e.mask);
            end
        end
    end

    initial begin
        rst = 1'b1;
        {test_start, test_done, test_pass, err_pulse, clr} = 5'b0;
        expect_at(0, mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL, "reset");
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

        // idle: nothing lit except the heartbeat
        for (int e = 1; e <= 20; e++)
            expect_at(e, mk(2'd0, 1'b0, l3x(2'd0, 1'b0, e), 1'b0, 1'b0, 1'b0), M_ALL, "idle");
        step(20);

        // clean pass
        test_start = 1'b1; step(1); test_start = 1'b0; s_cyc = cyc;
        expect_at(s_cyc, mk(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), M_ST, "run_state");
        expect_at(s_cyc + 1, mk(2'd1, 1'b0, l3x(2'd1, 1'b0, s_cyc + 1), 1'b0, 1'b0, phb(s_cyc + 1)), M_ALL, "run_led");
        step(10);
        expect_at(cyc, mk(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), M_ST, "run_hold");
        test_done = 1'b1; test_pass = 1'b1; step(1); test_done = 1'b0; test_pass = 1'b0; d_cyc = cyc;
        expect_at(d_cyc, mk(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), M_ST, "pass_state");
        expect_at(d_cyc + 1, mk(2'd2, 1'b0, l3x(2'd2, 1'b0, d_cyc + 1), 1'b0, 1'b1, 1'b0), M_ALL, "pass_led");
        step(3);

        // miscompare during run, engine still reports pass
        test_start = 1'b1; step(1); test_start = 1'b0; s_cyc = cyc;
        expect_at(s_cyc, mk(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), M_ST, "err_run");
        step(2);
        err_pulse = 1'b1; step(1); err_pulse = 1'b0; e_cyc = cyc;
        expect_at(e_cyc + 1, mk(2'd1, 1'b0, l3x(2'd1, 1'b0, e_cyc + 1), 1'b1, 1'b0, phb(e_cyc + 1)), M_ALL, "err_led");
        step(3);
        test_done = 1'b1; test_pass = 1'b1; step(1); test_done = 1'b0; test_pass = 1'b0; d_cyc = cyc;
        expect_at(d_cyc, mk(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), M_ST, "err_fail");
        for (int e = d_cyc + 1; e <= d_cyc + 16; e++)
            expect_at(e, mk(2'd3, 1'b0, l3x(2'd3, 1'b0, e), phb(e), 1'b0, 1'b0), M_ALL, "fail_blink");
        step(17);

        // timeout: fifth tick after entry forces FAIL
        test_start = 1'b1; step(1); test_start = 1'b0; s_cyc = cyc;
        t_cyc = (s_cyc / 4 + 5) * 4;
        expect_at(s_cyc, mk(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), M_ST, "to_run");
        expect_at(t_cyc - 1, mk(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), M_ST, "pre_timeout");
        expect_at(t_cyc, mk(2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), M_ST, "timeout_state");
        expect_at(t_cyc + 1, mk(2'd3, 1'b1, 1'b1, phb(t_cyc + 1), 1'b0, 1'b0), M_ALL, "timeout_led");
        step(t_cyc - s_cyc + 2);

        // start and clr together: start wins and clears flags
        test_start = 1'b1; clr = 1'b1; step(1); test_start = 1'b0; clr = 1'b0; s_cyc = cyc;
        expect_at(s_cyc, mk(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), M_ST, "start_clr");
        expect_at(s_cyc + 1, mk(2'd1, 1'b0, l3x(2'd1, 1'b0, s_cyc + 1), 1'b0, 1'b0, phb(s_cyc + 1)), M_ALL, "rearm_led");
        step(2);
        clr = 1'b1; step(1); clr = 1'b0; s_cyc = cyc;
        expect_at(s_cyc, mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), M_ST, "clr_state");
        expect_at(s_cyc + 1, mk(2'd0, 1'b0, l3x(2'd0, 1'b0, s_cyc + 1), 1'b0, 1'b0, 1'b0), M_ALL, "clr_led");
        step(2);

        // asynchronous reset pulse between edges mid-run
        test_start = 1'b1; step(1); test_start = 1'b0; s_cyc = cyc;
        expect_at(s_cyc, mk(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), M_ST, "pre_rst_run");
        step(3);
        @(negedge clk); #2;
        rst = 1'b1; #2; rst = 1'b0;
        expect_at(1, mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL, "async_rst");
        step(1);
        test_done = 1'b1; test_pass = 1'b1; step(1); test_done = 1'b0; test_pass = 1'b0;
        expect_at(cyc, mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), M_ST, "done_ignored");
        expect_at(cyc + 1, mk(2'd0, 1'b0, l3x(2'd0, 1'b0, cyc + 1), 1'b0, 1'b0, 1'b0), M_ALL, "done_ign_led");
        step(3);
        @(negedge clk); #1;

        while (q.size() > 0) begin
            mon_e = q.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL %0s: expectation for cycle %0d left unchecked", mon_e.tag, mon_e.cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
